dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbitrates the single-port data memory between the control-unit datapath (CPU side, driven by `dmem_read`/`dmem_write` sequencing) and the host loader that fills operand matrices before a run and reads results back afterward. Only one requester is granted per access slot. Contention is resolved round-robin, and a host lock gives the loader exclusive ownership for bulk transfers. The block sits between both requesters and the RAM, driving its enable, write-enable, address and write-data pins, and returns read data to the winner.

## Interface
- `DATA_W`, 16: data word width, matches processor `BUS_WIDTH`.
- `ADDR_W`, 8: data-memory address width.

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU access request, level.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_gnt`  out  1  one-cycle grant pulse.
- `cpu_rvalid`  out  1  one-cycle pulse when `cpu_rdata` is valid.
- `cpu_rdata`  out  DATA_W  read data, held until the next CPU read returns.
- `host_req`, `host_we`, `host_addr`, `host_wdata`, `host_gnt`, `host_rvalid`, `host_rdata`: same as the CPU set, for the host.
- `host_lock`  in  1  while high, CPU is never granted.
- `mem_en`  out  1  RAM access strobe.
- `mem_we`  out  1  RAM write enable, valid with `mem_en`.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_wdata`  out  DATA_W  RAM write data.
- `mem_rdata`  in  DATA_W  RAM read data, valid one cycle after `mem_en` for a read.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: evaluate requests.
  - GRANT: access on the RAM pins.
  - RECOVER: no sampling.
- IDLE:
  - With no eligible request, remain in IDLE with `mem_en` = 0.
  - Otherwise pick a winner, register `mem_en`=1 and the winner's `we`/`addr`/`wdata` onto the `mem_*` pins, pulse the winner's `gnt`, and go to GRANT.
- Eligibility: `host_req` is always eligible. `cpu_req` is eligible only when `host_lock`=0.
- Arbitration:
  - With one eligible requester, it wins.
  - With both eligible, the requester not granted last wins. `last_winner` resets to HOST, so the CPU wins the first tie.
- GRANT:
  - Clear `mem_en`, `mem_we` and the grant, and go to RECOVER.
  - For a read, latch the tag (owner = winner, pending = 1).
- RECOVER:
  - If a read is pending, capture `mem_rdata` into the owner's `rdata`, pulse the owner's `rvalid`, and clear pending.
  - Go to IDLE.
- Request handshake: the requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`. It may hold `req` high to queue its next access. Requests are not sampled in GRANT or RECOVER, so a single request is never granted twice.
- Writes produce no `rvalid`.
- `mem_addr`/`mem_wdata` hold their last values when `mem_en`=0. Only `mem_en`/`mem_we` are meaningful to the RAM.
- `host_lock` rising during GRANT/RECOVER does not abort the in-flight CPU access. It takes effect at the next IDLE evaluation.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State = IDLE, `last_winner` = HOST, pending = 0.
  - All outputs 0: `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, both `gnt`, both `rvalid`, both `rdata`, `busy`.
- Reset mid-access discards any in-flight read; no `rvalid` follows.
- Cycle numbering for a request sampled at edge T0:
  - T0–T1: `gnt`=1, `mem_en`=1, `busy`=1.
  - T1–T2: RAM drives `mem_rdata`.
  - T2–T3: `rvalid`=1 with `rdata`.
- Read latency: 2 cycles from grant to `rvalid`.
- Throughput: one access per 3 cycles (IDLE → GRANT → RECOVER → IDLE). Continuous alternating contention gives each side one access per 6 cycles.
- `busy` is high in GRANT and RECOVER. The CU stalls on `cpu_req & ~cpu_gnt`.
- `host_lock` with no host request: nothing is granted and `mem_en` stays 0. The CPU starves by design.

## Test plan
- Reset, then CPU read from address 0x10, RAM preloaded with 0x1234:
  - `cpu_gnt` 1 cycle after the sampling edge, with `mem_en`=1, `mem_we`=0, `mem_addr`=0x10.
  - `cpu_rvalid` 2 cycles later with `cpu_rdata`=0x1234.
  - `host_gnt` and `host_rvalid` stay 0 throughout.
- Host write of 0xBEEF to 0x05, then CPU read of 0x05:
  - `mem_we`=1 on the first grant.
  - The CPU receives 0xBEEF.
  - No `host_rvalid` is produced.
- Both sides hold `req` high for 4 accesses, `host_lock`=0:
  - Grant order is CPU, HOST, CPU, HOST.
  - Grants are spaced 3 cycles apart.
- `host_lock`=1, both sides requesting:
  - 3 consecutive host grants, no `cpu_gnt`.
  - When `host_lock` drops, the next grant goes to the CPU.
- `reset_n` pulsed low during RECOVER of a CPU read:
  - All outputs are immediately 0.
  - No `cpu_rvalid` follows.
  - The first post-reset tie goes to the CPU.
- Single request held one cycle then dropped after `gnt`:
  - Exactly one `mem_en` pulse.
  - No second grant.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin CPU/host arbiter for the single-port data memory
module dmem_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              host_lock,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic last_host;
    logic owner_host;
    logic pending;
    logic cpu_elig;
    logic host_elig;
    logic do_grant;
    logic pick_host;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // On a tie the host wins only if the CPU took the previous slot.
    always_comb begin
        cpu_elig  = cpu_req & ~host_lock;
        host_elig = host_req;
        do_grant  = 1'b0;
        pick_host = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cpu_elig | host_elig) begin
                    do_grant  = 1'b1;
                    pick_host = host_elig & (~cpu_elig | ~last_host);
                    state_nxt = GRANT;
                end
            end
            GRANT:   state_nxt = RECOVER;
            RECOVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_host   <= 1'b1;
            owner_host  <= 1'b0;
            pending     <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cpu_gnt     <= 1'b0;
            host_gnt    <= 1'b0;
            cpu_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
            cpu_rdata   <= '0;
            host_rdata  <= '0;
        end else begin
            cpu_gnt     <= 1'b0;
            host_gnt    <= 1'b0;
            cpu_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
            if (do_grant) begin
                mem_en    <= 1'b1;
                mem_we    <= pick_host ? host_we    : cpu_we;
                mem_addr  <= pick_host ? host_addr  : cpu_addr;
                mem_wdata <= pick_host ? host_wdata : cpu_wdata;
                cpu_gnt   <= ~pick_host;
                host_gnt  <= pick_host;
                last_host <= pick_host;
            end
            if (state == GRANT) begin
                mem_en     <= 1'b0;
                mem_we     <= 1'b0;
                pending    <= ~mem_we;
                owner_host <= last_host;
            end
            // The RAM returns read data in the cycle after the strobe, i.e. during RECOVER.
            if (state == RECOVER && pending) begin
                pending <= 1'b0;
                if (owner_host) begin
                    host_rdata  <= mem_rdata;
                    host_rvalid <= 1'b1;
                end else begin
                    cpu_rdata  <= mem_rdata;
                    cpu_rvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a RAM and slot-level model
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0]  cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_gnt, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        host_req = 1'b0, host_we = 1'b0;
    logic [7:0]  host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic        host_gnt, host_rvalid;
    logic [15:0] host_rdata;
    logic        host_lock = 1'b0;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.DATA_W(16), .ADDR_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .host_lock(host_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data appears the cycle after the strobe.
    logic [15:0] ram [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Slot-level model: a grant occupies a 3-cycle slot, a read answers 2 cycles later.
    logic [15:0] mmem [256];
    int          slot, rv_cnt;
    bit          rv_host, m_last_host, ce, he, win_host;
    logic [15:0] rv_data;
    logic        e_cpu_gnt, e_host_gnt, e_mem_en, e_mem_we, e_cpu_rv, e_host_rv, e_busy;
    logic [7:0]  e_mem_addr;
    logic [15:0] e_mem_wdata, e_cpu_rdata, e_host_rdata;

    always @(posedge clk) begin
        if (!reset_n) begin
            {e_cpu_gnt, e_host_gnt, e_mem_en, e_mem_we, e_cpu_rv, e_host_rv, e_busy} = '0;
            e_mem_addr = '0; e_mem_wdata = '0; e_cpu_rdata = '0; e_host_rdata = '0;
            slot = 0; rv_cnt = 0; m_last_host = 1'b1;
        end else begin
            {e_cpu_gnt, e_host_gnt, e_mem_en, e_mem_we, e_cpu_rv, e_host_rv} = '0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    if (rv_host) begin e_host_rv = 1'b1; e_host_rdata = rv_data; end
                    else         begin e_cpu_rv  = 1'b1; e_cpu_rdata  = rv_data; end
                end
            end
            if (slot > 0) begin
                slot--;
                e_busy = (slot > 0);
            end else begin
                ce = cpu_req && !host_lock;
                he = host_req;
                if (ce || he) begin
                    if (ce && he) win_host = !m_last_host;
                    else          win_host = he;
                    m_last_host = win_host;
                    slot = 2; e_busy = 1'b1; e_mem_en = 1'b1;
                    e_cpu_gnt = !win_host; e_host_gnt = win_host;
                    e_mem_we    = win_host ? host_we    : cpu_we;
                    e_mem_addr  = win_host ? host_addr  : cpu_addr;
                    e_mem_wdata = win_host ? host_wdata : cpu_wdata;
                    if (e_mem_we) mmem[e_mem_addr] = e_mem_wdata;
                    else begin rv_cnt = 2; rv_host = win_host; rv_data = mmem[e_mem_addr]; end
                end else begin
                    e_busy = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    int n_cpu_gnt = 0, n_host_gnt = 0, n_cpu_rv = 0, n_host_rv = 0, n_mem_en = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            chk("cpu_gnt", cpu_gnt, e_cpu_gnt);
            chk("host_gnt", host_gnt, e_host_gnt);
            chk("mem_en", mem_en, e_mem_en);
            chk("mem_we", mem_we, e_mem_we);
            chk("mem_addr", mem_addr, e_mem_addr);
            chk("mem_wdata", mem_wdata, e_mem_wdata);
            chk("cpu_rvalid", cpu_rvalid, e_cpu_rv);
            chk("host_rvalid", host_rvalid, e_host_rv);
            chk("cpu_rdata", cpu_rdata, e_cpu_rdata);
            chk("host_rdata", host_rdata, e_host_rdata);
            chk("busy", busy, e_busy);
            n_cpu_gnt  += int'(cpu_gnt);
            n_host_gnt += int'(host_gnt);
            n_cpu_rv   += int'(cpu_rvalid);
            n_host_rv  += int'(host_rvalid);
            n_mem_en   += int'(mem_en);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_gnt(input bit host, output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (host ? host_gnt : cpu_gnt) begin n = i; break; end
        end
        checks++;
        if (n == 0) begin
            errors++;
            $display("FAIL gnt_timeout actual=none required=%s grant", host ? "host" : "cpu");
        end
    endtask

    // Waits for the next grant of either side; returns 1 for host, 0 for CPU.
    task automatic next_grant(output bit who, output int cyc);
        who = 1'b0; cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (cpu_gnt || host_gnt) begin who = host_gnt; cyc = i; break; end
        end
        checks++;
        if (cyc == 0) begin
            errors++;
            $display("FAIL any_gnt_timeout actual=none required=grant");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    int n, c0, who_i;
    bit who;
    bit exp_order [4];
    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]  = 16'hA000 | 16'(i);
            mmem[i] = 16'hA000 | 16'(i);
        end
        ram[8'h10]  = 16'h1234;
        mmem[8'h10] = 16'h1234;
        exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;

        tick(); tick();
        chk("reset_busy", busy, 0);
        chk("reset_mem_en", mem_en, 0);
        chk("reset_cpu_rdata", cpu_rdata, 0);
        reset_n = 1'b1;

        // CPU read of 0x10
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        wait_gnt(1'b0, n);
        chk("t1_gnt_latency", n, 1);
        chk("t1_mem_en", mem_en, 1);
        chk("t1_mem_we", mem_we, 0);
        chk("t1_mem_addr", mem_addr, 8'h10);
        cpu_req = 1'b0;
        tick();
        chk("t1_rvalid_early", cpu_rvalid, 0);
        tick();
        chk("t1_rvalid", cpu_rvalid, 1);
        chk("t1_rdata", cpu_rdata, 16'h1234);
        chk("t1_no_host_gnt", n_host_gnt, 0);

        // Host write 0xBEEF to 0x05, then CPU reads it back
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h05; host_wdata = 16'hBEEF;
        wait_gnt(1'b1, n);
        chk("t2_mem_we", mem_we, 1);
        chk("t2_mem_addr", mem_addr, 8'h05);
        chk("t2_mem_wdata", mem_wdata, 16'hBEEF);
        host_req = 1'b0; host_we = 1'b0;
        cpu_req = 1'b1; cpu_addr = 8'h05;
        wait_gnt(1'b0, n);
        cpu_req = 1'b0;
        tick(); tick();
        chk("t2_rvalid", cpu_rvalid, 1);
        chk("t2_rdata", cpu_rdata, 16'hBEEF);
        tick();
        chk("t2_no_host_rvalid", n_host_rv, 0);

        // Round-robin under continuous contention
        do_reset();
        cpu_req = 1'b1; cpu_addr = 8'h20; host_req = 1'b1; host_addr = 8'h30;
        for (int k = 0; k < 4; k++) begin
            next_grant(who, n);
            chk("t3_order", who, exp_order[k]);
            if (k > 0) chk("t3_spacing", n, 3);
        end
        cpu_req = 1'b0; host_req = 1'b0;

        // Host lock: host only, then CPU wins once lock drops
        tick(); tick(); tick();
        c0 = n_cpu_gnt;
        host_lock = 1'b1; cpu_req = 1'b1; host_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_grant(who, n);
            chk("t4_locked_host", who, 1);
        end
        chk("t4_no_cpu_gnt", n_cpu_gnt - c0, 0);
        host_lock = 1'b0;
        next_grant(who, n);
        chk("t4_unlock_cpu", who, 0);
        cpu_req = 1'b0; host_req = 1'b0;
        tick(); tick(); tick();

        // Reset during RECOVER of a CPU read
        do_reset();
        cpu_req = 1'b1; cpu_addr = 8'h10;
        wait_gnt(1'b0, n);
        cpu_req = 1'b0;
        tick();
        c0 = n_cpu_rv;
        reset_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_mem_en", mem_en, 0);
        chk("t5_mem_addr", mem_addr, 0);
        chk("t5_mem_wdata", mem_wdata, 0);
        chk("t5_cpu_rv", cpu_rvalid, 0);
        chk("t5_cpu_rdata", cpu_rdata, 0);
        chk("t5_gnts", {cpu_gnt, host_gnt, host_rvalid, mem_we}, 0);
        tick(); tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("t5_no_rvalid", n_cpu_rv - c0, 0);
        cpu_req = 1'b1; host_req = 1'b1; host_addr = 8'h31;
        next_grant(who, n);
        chk("t5_tie_cpu", who, 0);
        cpu_req = 1'b0; host_req = 1'b0;
        tick(); tick(); tick(); tick();

        // Single request dropped after grant
        c0 = n_mem_en;
        who_i = n_host_gnt;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h07;
        wait_gnt(1'b1, n);
        host_req = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("t6_one_mem_en", n_mem_en - c0, 1);
        chk("t6_one_gnt", n_host_gnt - who_i, 1);
        chk("t6_host_rdata", host_rdata, 16'hA007);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
